// File: rtl/mult_arb_pkg.sv
// Shared types and helpers for the multiplier-sharing arbiter.
// State encoding and sizing helpers used by the top and the round-robin arbiter.
package mult_arb_pkg;

    localparam logic [1:0] ST_IDLE  = 2'b00;
    localparam logic [1:0] ST_ISSUE = 2'b01;
    localparam logic [1:0] ST_WAIT  = 2'b10;
    localparam logic [1:0] ST_RESP  = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = ST_IDLE,
        ISSUE = ST_ISSUE,
        WAIT  = ST_WAIT,
        RESP  = ST_RESP
    } state_t;

    // Ceiling log2, at least 1 so that derived vectors never collapse to zero width.
    function automatic int clog2(input int value);
        int result;
        result = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/mult_arbiter_if.sv
// Requester-side bus of the multiplier arbiter: operation request and result return.
interface mult_arbiter_if #(
    parameter int N    = 4,
    parameter int NREQ = 4
);
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*N-1:0] req_a;
    logic [NREQ*N-1:0] req_b;
    logic [NREQ-1:0]   resp_valid;
    logic [2*N-1:0]    resp_r;
    logic              resp_err;
    logic [NREQ-1:0]   resp_ack;

    // Arbiter side
    modport slave (
        input  req_valid, req_a, req_b, resp_ack,
        output req_ready, resp_valid, resp_r, resp_err
    );

    // Requester side
    modport master (
        output req_valid, req_a, req_b, resp_ack,
        input  req_ready, resp_valid, resp_r, resp_err
    );
endinterface

// File: rtl/mult_arbiter_rr.sv
// Combinational round-robin arbiter: first asserted request at or after ptr, wrapping.
// Produces a one-hot grant, the grant index and an any-grant flag.
module rr_arbiter
    import mult_arb_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int PW   = clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    output logic [NREQ-1:0] grant,
    output logic [PW-1:0]   grant_idx,
    output logic            grant_any
);

    int cand;

    // Scan from the farthest offset down so the closest request to ptr wins.
    always_comb begin
        grant_idx = '0;
        grant_any = 1'b0;
        cand      = 0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            cand = int'(ptr) + k;
            if (cand >= NREQ) begin
                cand = cand - NREQ;
            end
            if (req[PW'(cand)]) begin
                grant_idx = PW'(cand);
                grant_any = 1'b1;
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_grant
            assign grant[gi] = grant_any && (grant_idx == PW'(gi));
        end
    endgenerate

endmodule

// File: rtl/mult_arbiter.sv
// Shares one multi-cycle multiplier among NREQ requesters with round-robin grant,
// a single job in flight, and a watchdog that aborts a stalled multiplication.
module mult_arbiter
    import mult_arb_pkg::*;
#(
    parameter int N       = 4,
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 64
) (
    input  logic            clk,
    input  logic            rst_n,
    mult_arbiter_if.slave   rbus,
    output logic            mul_set,
    output logic [N-1:0]    mul_a,
    output logic [N-1:0]    mul_b,
    input  logic            mul_ready,
    input  logic [2*N-1:0]  mul_r,
    output logic            busy
);

    localparam int PW = clog2(NREQ);
    localparam int WW = (TIMEOUT > 1) ? clog2(TIMEOUT) : 1;
    localparam logic [WW-1:0] WD_LAST = (TIMEOUT > 0) ? WW'(TIMEOUT - 1) : '0;

    state_t          state_reg;
    logic [PW-1:0]   ptr_reg;
    logic [PW-1:0]   owner_reg;
    logic [WW-1:0]   wd_reg;
    logic [N-1:0]    mul_a_reg;
    logic [N-1:0]    mul_b_reg;
    logic            mul_set_reg;
    logic [2*N-1:0]  resp_r_reg;
    logic            resp_err_reg;
    logic [NREQ-1:0] resp_valid_reg;
    logic            busy_reg;

    logic [NREQ-1:0] grant;
    logic [PW-1:0]   grant_idx;
    logic            grant_any;
    logic [NREQ-1:0] owner_hot;
    logic [N-1:0]    a_slice [NREQ];
    logic [N-1:0]    b_slice [NREQ];

    rr_arbiter #(
        .NREQ (NREQ),
        .PW   (PW)
    ) u_rr (
        .req       (rbus.req_valid),
        .ptr       (ptr_reg),
        .grant     (grant),
        .grant_idx (grant_idx),
        .grant_any (grant_any)
    );

    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_slice
            assign a_slice[gi]   = rbus.req_a[gi*N +: N];
            assign b_slice[gi]   = rbus.req_b[gi*N +: N];
            assign owner_hot[gi] = (owner_reg == PW'(gi));
        end
    endgenerate

    // Accept is Mealy so a requester sees ready in the same cycle it is chosen.
    assign rbus.req_ready  = (state_reg == IDLE) ? grant : '0;
    assign rbus.resp_valid = resp_valid_reg;
    assign rbus.resp_r     = resp_r_reg;
    assign rbus.resp_err   = resp_err_reg;
    assign mul_set         = mul_set_reg;
    assign mul_a           = mul_a_reg;
    assign mul_b           = mul_b_reg;
    assign busy            = busy_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            ptr_reg        <= '0;
            owner_reg      <= '0;
            wd_reg         <= '0;
            mul_a_reg      <= '0;
            mul_b_reg      <= '0;
            mul_set_reg    <= 1'b0;
            resp_r_reg     <= '0;
            resp_err_reg   <= 1'b0;
            resp_valid_reg <= '0;
            busy_reg       <= 1'b0;
        end else begin
            mul_set_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (grant_any) begin
                        mul_a_reg   <= a_slice[grant_idx];
                        mul_b_reg   <= b_slice[grant_idx];
                        owner_reg   <= grant_idx;
                        ptr_reg     <= (grant_idx == PW'(NREQ - 1)) ? '0 : grant_idx + 1'b1;
                        mul_set_reg <= 1'b1;
                        busy_reg    <= 1'b1;
                        state_reg   <= ISSUE;
                    end
                end
                ISSUE: begin
                    wd_reg    <= '0;
                    state_reg <= WAIT;
                end
                WAIT: begin
                    // A completing multiplier beats a simultaneous watchdog expiry.
                    if (mul_ready) begin
                        resp_r_reg     <= mul_r;
                        resp_err_reg   <= 1'b0;
                        resp_valid_reg <= owner_hot;
                        state_reg      <= RESP;
                    end else if ((TIMEOUT != 0) && (wd_reg == WD_LAST)) begin
                        resp_r_reg     <= '0;
                        resp_err_reg   <= 1'b1;
                        resp_valid_reg <= owner_hot;
                        state_reg      <= RESP;
                    end else begin
                        wd_reg <= wd_reg + 1'b1;
                    end
                end
                RESP: begin
                    if (rbus.resp_ack[owner_reg]) begin
                        resp_valid_reg <= '0;
                        busy_reg       <= 1'b0;
                        state_reg      <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule
